// File: rtl/wb_dcache_flush_ctrl.sv
// Data-cache flush walker: visits every set/way, writes back dirty lines, invalidates valid ones.
// Optional macro WB_DCACHE_FLUSH_PERF_CNT_EN adds wb_count_o, a writeback handshake counter.
module wb_dcache_flush_ctrl #(
    parameter int NUM_SETS = 256,
    parameter int NUM_WAYS = 8,
    localparam int SET_W = $clog2(NUM_SETS),
    localparam int WAY_W = $clog2(NUM_WAYS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_req_i,
    output logic             flush_ack_o,
    output logic             busy_o,
    output logic             tag_req_o,
    input  logic             tag_gnt_i,
    output logic [SET_W-1:0] tag_set_o,
    output logic [WAY_W-1:0] tag_way_o,
    input  logic             tag_rvalid_i,
    input  logic             tag_valid_i,
    input  logic             tag_dirty_i,
    output logic             wb_req_o,
    input  logic             wb_gnt_i,
    output logic [SET_W-1:0] wb_set_o,
    output logic [WAY_W-1:0] wb_way_o,
    input  logic             wb_done_i,
    output logic             inv_req_o,
    input  logic             inv_gnt_i
`ifdef WB_DCACHE_FLUSH_PERF_CNT_EN
    ,
    output logic [SET_W+WAY_W:0] wb_count_o
`endif
);

    typedef enum logic [2:0] {
        IDLE, TAG_RD, TAG_WAIT, WB_REQ, WB_WAIT, INV, NEXT, DONE
    } state_t;

    localparam logic [SET_W-1:0] SET_LAST = SET_W'(NUM_SETS - 1);
    localparam logic [WAY_W-1:0] WAY_LAST = WAY_W'(NUM_WAYS - 1);

    state_t           state_q, state_d;
    logic [SET_W-1:0] set_q, set_d;
    logic [WAY_W-1:0] way_q, way_d;
    logic             tag_req, wb_req, inv_req, ack;

    // State and line counters; reset abandons any flush in progress
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            set_q   <= '0;
            way_q   <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            way_q   <= way_d;
        end
    end

    // Next-state logic, request strobes and line counter advance
    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        way_d   = way_q;
        tag_req = 1'b0;
        wb_req  = 1'b0;
        inv_req = 1'b0;
        ack     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush_req_i) begin
                    set_d   = '0;
                    way_d   = '0;
                    state_d = TAG_RD;
                end
            end
            TAG_RD: begin
                tag_req = 1'b1;
                if (tag_gnt_i) state_d = TAG_WAIT;
            end
            TAG_WAIT: begin
                if (tag_rvalid_i) begin
                    if (!tag_valid_i)     state_d = NEXT;
                    else if (tag_dirty_i) state_d = WB_REQ;
                    else                  state_d = INV;
                end
            end
            WB_REQ: begin
                wb_req = 1'b1;
                if (wb_gnt_i) state_d = WB_WAIT;
            end
            WB_WAIT: begin
                if (wb_done_i) state_d = INV;
            end
            INV: begin
                inv_req = 1'b1;
                if (inv_gnt_i) state_d = NEXT;
            end
            NEXT: begin
                if (set_q == SET_LAST && way_q == WAY_LAST) begin
                    state_d = DONE;
                end else if (way_q == WAY_LAST) begin
                    way_d   = '0;
                    set_d   = set_q + 1'b1;
                    state_d = TAG_RD;
                end else begin
                    way_d   = way_q + 1'b1;
                    state_d = TAG_RD;
                end
            end
            DONE: begin
                ack     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is asserted, even before the edge
    always_comb begin
        tag_req_o   = tag_req & ~rst_i;
        wb_req_o    = wb_req & ~rst_i;
        inv_req_o   = inv_req & ~rst_i;
        flush_ack_o = ack & ~rst_i;
        busy_o      = (state_q != IDLE) & ~rst_i;
        tag_set_o   = rst_i ? '0 : set_q;
        tag_way_o   = rst_i ? '0 : way_q;
        wb_set_o    = rst_i ? '0 : set_q;
        wb_way_o    = rst_i ? '0 : way_q;
    end

`ifdef WB_DCACHE_FLUSH_PERF_CNT_EN
    // Writeback handshake counter, cleared when a new flush is accepted
    always_ff @(posedge clk_i) begin
        if (rst_i)
            wb_count_o <= '0;
        else if (state_q == IDLE && flush_req_i)
            wb_count_o <= '0;
        else if (wb_req && wb_gnt_i)
            wb_count_o <= wb_count_o + 1'b1;
    end
`endif

endmodule

// File: tb/tb_wb_dcache_flush_ctrl.sv
// Randomized scoreboard bench for wb_dcache_flush_ctrl against a line-walk reference model.
// Checks wb_count_o as well when WB_DCACHE_FLUSH_PERF_CNT_EN is defined.
module tb_wb_dcache_flush_ctrl;

    localparam int NS = 256;
    localparam int NW = 8;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       flush_req_i = 1'b0;
    logic       flush_ack_o, busy_o;
    logic       tag_req_o, tag_gnt_i = 1'b0;
    logic [7:0] tag_set_o;
    logic [2:0] tag_way_o;
    logic       tag_rvalid_i = 1'b0, tag_valid_i = 1'b0, tag_dirty_i = 1'b0;
    logic       wb_req_o, wb_gnt_i = 1'b0;
    logic [7:0] wb_set_o;
    logic [2:0] wb_way_o;
    logic       wb_done_i = 1'b0;
    logic       inv_req_o, inv_gnt_i = 1'b0;
`ifdef WB_DCACHE_FLUSH_PERF_CNT_EN
    logic [11:0] wb_count_o;
`endif

    wb_dcache_flush_ctrl #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_req_i(flush_req_i),
        .flush_ack_o(flush_ack_o), .busy_o(busy_o),
        .tag_req_o(tag_req_o), .tag_gnt_i(tag_gnt_i),
        .tag_set_o(tag_set_o), .tag_way_o(tag_way_o),
        .tag_rvalid_i(tag_rvalid_i), .tag_valid_i(tag_valid_i),
        .tag_dirty_i(tag_dirty_i),
        .wb_req_o(wb_req_o), .wb_gnt_i(wb_gnt_i),
        .wb_set_o(wb_set_o), .wb_way_o(wb_way_o), .wb_done_i(wb_done_i),
        .inv_req_o(inv_req_o), .inv_gnt_i(inv_gnt_i)
`ifdef WB_DCACHE_FLUSH_PERF_CNT_EN
        , .wb_count_o(wb_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int kind;
        int set;
        int way;
    } ev_t;

    ev_t sb[$];
    bit  vld[NS][NW];
    bit  drt[NS][NW];
    int  vectors = 0;
    int  miscompares = 0;
    int  acks = 0;
    int  exp_wb = 0;
    bit  hold_done = 0;

    task automatic chk(string name, longint act, longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic int dly();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    // Reference model: the expected event stream of one flush over the current cache image
    task automatic push_flush();
        exp_wb = 0;
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                sb.push_back('{0, s, w});
                if (vld[s][w]) begin
                    if (drt[s][w]) begin
                        sb.push_back('{1, s, w});
                        exp_wb++;
                    end
                    sb.push_back('{2, s, w});
                end
            end
        sb.push_back('{3, 0, 0});
    endtask

    task automatic pop_cmp(int kind, int s, int w);
        ev_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d at %0d/%0d, required none",
                     kind, s, w);
        end else begin
            e = sb.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind != 3) chk("event_line", s * NW + w, e.set * NW + e.way);
        end
    endtask

    // Tag array responder: random grant latency, then the stored valid/dirty bits
    initial begin
        int  gcnt = 0, rcnt = 0, ps = 0, pw = 0;
        bit  pend = 0;
        forever begin
            @(posedge clk_i); #2;
            tag_gnt_i = 0;
            tag_rvalid_i = 0;
            tag_valid_i = 1'($urandom);
            tag_dirty_i = 1'($urandom);
            if (rst_i) begin
                pend = 0;
            end else if (pend) begin
                if (rcnt == 0) begin
                    tag_rvalid_i = 1;
                    tag_valid_i = vld[ps][pw];
                    tag_dirty_i = drt[ps][pw];
                    pend = 0;
                end else rcnt--;
            end else if (tag_req_o) begin
                if (gcnt == 0) begin
                    tag_gnt_i = 1;
                    pend = 1;
                    ps = int'(tag_set_o);
                    pw = int'(tag_way_o);
                    rcnt = dly();
                    gcnt = dly();
                end else gcnt--;
            end else if ($urandom_range(0, 7) == 0) begin
                tag_rvalid_i = 1;
            end
        end
    end

    // Writeback engine responder with long random grant/done latencies
    initial begin
        int gcnt = 0, dcnt = 0;
        bit pend = 0;
        forever begin
            @(posedge clk_i); #2;
            wb_gnt_i = 0;
            wb_done_i = 0;
            if (rst_i) begin
                pend = 0;
            end else if (pend) begin
                if (!hold_done) begin
                    if (dcnt == 0) begin
                        wb_done_i = 1;
                        pend = 0;
                    end else dcnt--;
                end
            end else if (wb_req_o) begin
                if (gcnt == 0) begin
                    wb_gnt_i = 1;
                    pend = 1;
                    dcnt = $urandom_range(0, 12);
                    gcnt = $urandom_range(0, 5);
                end else gcnt--;
            end else if ($urandom_range(0, 7) == 0) begin
                wb_done_i = 1;
            end
        end
    end

    // Invalidate responder: clears the cache image line on grant
    initial begin
        int gcnt = 0;
        forever begin
            @(posedge clk_i); #2;
            inv_gnt_i = 0;
            if (!rst_i && inv_req_o) begin
                if (gcnt == 0) begin
                    inv_gnt_i = 1;
                    vld[tag_set_o][tag_way_o] = 0;
                    drt[tag_set_o][tag_way_o] = 0;
                    gcnt = dly();
                end else gcnt--;
            end
        end
    end

    // Monitor: handshake events against the scoreboard plus per-cycle protocol checks
    initial begin
        bit   p_hold = 0, p_ack = 0, p_rst = 1;
        bit   p_tag = 0, p_wb = 0, p_inv = 0;
        logic [21:0] p_lines = '0;
        logic [21:0] lines;
        forever begin
            @(negedge clk_i);
            lines = {tag_set_o, tag_way_o, wb_set_o, wb_way_o};
            chk("req_onehot", int'(tag_req_o) + int'(wb_req_o) + int'(inv_req_o) <= 1, 1);
            chk("set_way_agree", {tag_set_o, tag_way_o}, {wb_set_o, wb_way_o});
            if (!rst_i && !p_rst) begin
                if (p_hold) chk("line_stable", lines, p_lines);
                if (p_tag) chk("tag_req_held", tag_req_o, 1);
                if (p_wb)  chk("wb_req_held", wb_req_o, 1);
                if (p_inv) chk("inv_req_held", inv_req_o, 1);
            end
            if (p_ack) begin
                chk("ack_width", flush_ack_o, 0);
                chk("busy_after_ack", busy_o, 0);
            end
            if (tag_req_o && tag_gnt_i) pop_cmp(0, tag_set_o, tag_way_o);
            if (wb_req_o && wb_gnt_i)   pop_cmp(1, wb_set_o, wb_way_o);
            if (inv_req_o && inv_gnt_i) pop_cmp(2, tag_set_o, tag_way_o);
            if (flush_ack_o) begin
                pop_cmp(3, 0, 0);
                acks++;
            end
            p_tag = tag_req_o && !tag_gnt_i;
            p_wb = wb_req_o && !wb_gnt_i;
            p_inv = inv_req_o && !inv_gnt_i;
            p_hold = p_tag || p_wb || p_inv;
            p_lines = lines;
            p_ack = flush_ack_o;
            p_rst = rst_i;
        end
    end

    task automatic check_quiet(string name);
        chk(name, {tag_req_o, wb_req_o, inv_req_o, flush_ack_o, busy_o,
                   tag_set_o, tag_way_o, wb_set_o, wb_way_o}, 0);
    endtask

    task automatic chk_count(string name);
`ifdef WB_DCACHE_FLUSH_PERF_CNT_EN
        chk(name, wb_count_o, exp_wb);
`else
        chk(name, sb.size(), 0);
`endif
    endtask

    task automatic wait_ack(int n);
        int t = 0;
        while (acks < n && t < 40000) begin
            @(posedge clk_i);
            t++;
        end
        if (acks < n) begin
            chk("ack_timeout", acks, n);
            sb.delete();
        end
    endtask

    task automatic run_flush(string name);
        int n = acks + 1;
        push_flush();
        @(posedge clk_i); #1;
        flush_req_i = 1;
        @(posedge clk_i); #1;
        flush_req_i = 0;
        @(negedge clk_i);
        chk({name, "_busy"}, busy_o, 1);
        wait_ack(n);
        @(negedge clk_i);
        chk({name, "_drained"}, sb.size(), 0);
        chk_count({name, "_wbcount"});
    endtask

    task automatic fill(int vmod, bit dirty_rand);
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                vld[s][w] = (vmod == 0) ? 1'b0 : ($urandom_range(0, vmod - 1) == 0);
                drt[s][w] = dirty_rand ? 1'($urandom) : 1'b0;
            end
    endtask

    // Scenario sequencer
    initial begin
        int t;
        int n;
        fill(0, 0);
        repeat (3) @(negedge clk_i);
        check_quiet("reset_quiet");
        @(posedge clk_i); #1;
        rst_i = 0;
        @(negedge clk_i);
        check_quiet("post_reset_idle");

        fill(0, 0);
        run_flush("all_invalid");

        fill(1, 0);
        vld[5][3] = 1;
        drt[5][3] = 1;
        run_flush("one_dirty");

        fill(8, 1);
        vld[255][7] = 1;
        drt[255][7] = 1;
        run_flush("random_last_dirty");

        fill(0, 0);
        vld[100][0] = 1;
        drt[100][0] = 1;
        push_flush();
        hold_done = 1;
        @(posedge clk_i); #1;
        flush_req_i = 1;
        @(posedge clk_i); #1;
        flush_req_i = 0;
        t = 0;
        while (!(wb_req_o && wb_gnt_i) && t < 20000) begin
            @(negedge clk_i);
            t++;
        end
        chk("reach_wb_wait", wb_set_o, 100);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1;
        @(negedge clk_i);
        check_quiet("mid_flush_reset");
        @(posedge clk_i); #1;
        rst_i = 0;
        sb.delete();
        hold_done = 0;
        exp_wb = 0;
        @(negedge clk_i);
        check_quiet("after_abort");
        chk_count("abort_wbcount");
        repeat (30) @(negedge clk_i);
        chk("abort_no_resume", {busy_o, 31'(acks)}, {1'b0, 31'(acks)});
        chk("abort_line_kept", vld[100][0], 1);

        run_flush("restart");

        fill(0, 0);
        n = acks;
        push_flush();
        push_flush();
        @(posedge clk_i); #1;
        flush_req_i = 1;
        wait_ack(n + 1);
        @(posedge clk_i); #1;
        flush_req_i = 0;
        wait_ack(n + 2);
        repeat (10) @(negedge clk_i);
        chk("b2b_idle", busy_o, 0);
        chk("b2b_drained", sb.size(), 0);
        chk("b2b_acks", acks, n + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
